// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, lane indices and FSM states.
// Also holds the alignment rule used to reject requests before touching memory.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam int LANE_W    = 8;
    localparam int NUM_LANES = 4;

    // Little-endian lane numbering: LANE0 is bits 7:0
    localparam logic [1:0] LANE0 = 2'd0;
    localparam logic [1:0] LANE1 = 2'd1;
    localparam logic [1:0] LANE2 = 2'd2;
    localparam logic [1:0] LANE3 = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_CAP,
        ST_WR,
        ST_RESP
    } state_e;

    function automatic logic req_bad(input logic [1:0] size, input logic [1:0] lo);
        return (size == SZ_ILL) ||
               ((size == SZ_HALF) && lo[0]) ||
               ((size == SZ_WORD) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_lane_mux.sv
// Combinational lane logic: merges store data into a memory word and extracts
// sign/zero-extended load data from it.
module lsu_lane_mux
    import lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] rword_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] merged_o,
    output logic [31:0] rdata_o
);

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic byte_hit;
            logic half_hit;

            assign byte_hit = (size_i == SZ_BYTE) && (lane_i == 2'(gi));
            assign half_hit = (size_i == SZ_HALF) && (lane_i[1] == 1'(gi >> 1));

            // Half stores take the low or high byte of wdata[15:0] depending on lane parity
            assign merged_o[LANE_W*gi +: LANE_W] =
                (size_i == SZ_WORD) ? wdata_i[LANE_W*gi +: LANE_W] :
                byte_hit            ? wdata_i[7:0] :
                half_hit            ? wdata_i[LANE_W*(gi % 2) +: LANE_W] :
                                      rword_i[LANE_W*gi +: LANE_W];
        end
    endgenerate

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'h00;
        case (lane_i)
            LANE0:   byte_sel = rword_i[7:0];
            LANE1:   byte_sel = rword_i[15:8];
            LANE2:   byte_sel = rword_i[23:16];
            LANE3:   byte_sel = rword_i[31:24];
            default: byte_sel = 8'h00;
        endcase
        half_sel = lane_i[1] ? rword_i[31:16] : rword_i[15:0];

        rdata_o = 32'h0;
        case (size_i)
            SZ_BYTE: rdata_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
            SZ_HALF: rdata_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
            SZ_WORD: rdata_o = rword_i;
            default: rdata_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit in front of a word-wide memory: alignment checks, read-modify-write
// for sub-word stores and extended load data, driven by a five-state FSM.
module mem_lsu
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_dataout
);

    state_e                state_q;
    logic                  ready_q;
    logic                  resp_valid_q;
    logic                  resp_err_q;
    logic [DATA_WIDTH-1:0] resp_rdata_q;
    logic                  mem_we_q;
    logic [DATA_WIDTH-1:0] mem_data_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [1:0]            size_q;
    logic                  we_q;
    logic                  uns_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic                  bad_d;
    logic [DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH-1:0] extracted;

    assign bad_d = req_bad(req_size, req_addr[1:0]);

    // The lane mux looks straight at mem_dataout during CAP, so the captured read
    // lands directly in the registered write data or load result.
    lsu_lane_mux u_lane_mux (
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .lane_i     (addr_q[1:0]),
        .rword_i    (mem_dataout),
        .wdata_i    (wdata_q),
        .merged_o   (merged),
        .rdata_o    (extracted)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            mem_we_q     <= 1'b0;
            mem_data_q   <= '0;
            addr_q       <= '0;
            size_q       <= SZ_BYTE;
            we_q         <= 1'b0;
            uns_q        <= 1'b0;
            wdata_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        size_q  <= req_size;
                        we_q    <= req_we;
                        uns_q   <= req_unsigned;
                        wdata_q <= req_wdata;
                        ready_q <= 1'b0;
                        if (bad_d) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end else if (req_we && (req_size == SZ_WORD)) begin
                            state_q    <= ST_WR;
                            mem_we_q   <= 1'b1;
                            mem_data_q <= req_wdata;
                        end else begin
                            state_q <= ST_RD;
                        end
                    end
                end
                ST_RD: state_q <= ST_CAP;
                ST_CAP: begin
                    if (we_q) begin
                        state_q    <= ST_WR;
                        mem_we_q   <= 1'b1;
                        mem_data_q <= merged;
                    end else begin
                        state_q      <= ST_RESP;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= extracted;
                    end
                end
                ST_WR: begin
                    state_q      <= ST_RESP;
                    mem_we_q     <= 1'b0;
                    resp_valid_q <= 1'b1;
                end
                ST_RESP: begin
                    state_q      <= ST_IDLE;
                    ready_q      <= 1'b1;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    ready_q  <= 1'b1;
                    mem_we_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_addr   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign mem_data   = mem_data_q;
    // A reset arriving during WR must kill the write in that same cycle
    assign mem_we     = mem_we_q & ~rst;

endmodule
